// File: rtl/device_serial_tx.sv
// Memory-mapped console device: an 8-bit bus target with a TX FIFO feeding an 8N1 serializer,
// plus a single-byte RX holding register loaded from the host side.
module device_serial_tx #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        _cs,
    input  logic        _oe,
    input  logic        _w,
    input  logic [19:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        tx,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int KW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [KW-1:0] BIT_LAST = KW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Only the register offset is decoded; upper address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[19:2];

    // ---------------------------------------------------------------
    // Bus strobe edge detection
    // ---------------------------------------------------------------
    logic       wr_act;
    logic       rd_act;
    logic       wr_prev_reg;
    logic       rd_prev_reg;
    logic [1:0] rd_addr_reg;
    logic       push_req;
    logic       rd_end;
    logic       data_clr;
    logic       stat_clr;

    assign wr_act = ~_cs & ~_w;
    // A concurrent write strobe suppresses the read so it never has side effects.
    assign rd_act = ~_cs & ~_oe & _w;

    assign push_req = wr_act & ~wr_prev_reg & (addr[1:0] == 2'd0);
    assign rd_end   = rd_prev_reg & ~rd_act;
    assign data_clr = rd_end & (rd_addr_reg == 2'd0);
    assign stat_clr = rd_end & (rd_addr_reg == 2'd1);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wr_prev_reg <= 1'b0;
            rd_prev_reg <= 1'b0;
            rd_addr_reg <= 2'd0;
        end else begin
            wr_prev_reg <= wr_act;
            rd_prev_reg <= rd_act;
            if (rd_act) begin
                rd_addr_reg <= addr[1:0];
            end
        end
    end

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [7:0]    fifo_head;
    logic          pop;
    logic          push_ok;
    logic          fifo_empty;

    assign fifo_empty = (count_reg == '0);
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    // A full FIFO still accepts a byte when the serializer drains one on the same edge.
    assign push_ok    = push_req & ((count_reg != DEPTH_C) | pop);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    // ---------------------------------------------------------------
    // 8N1 serializer
    // ---------------------------------------------------------------
    state_t        state_reg;
    state_t        state_next;
    logic [KW-1:0] clk_cnt_reg;
    logic [KW-1:0] clk_cnt_next;
    logic [2:0]    bit_idx_reg;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          bit_end;

    assign bit_end = (clk_cnt_reg == BIT_LAST);

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_head;
                    clk_cnt_next = '0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + KW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + KW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    // Chain straight into the next start bit so queued bytes leave back-to-back.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + KW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_reg   <= S_IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'h00;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // RX holding register and sticky error flags
    // ---------------------------------------------------------------
    logic [7:0] rx_hold_reg;
    logic       rx_full_reg;
    logic       rx_overrun_reg;
    logic       tx_overflow_reg;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rx_hold_reg     <= 8'h00;
            rx_full_reg     <= 1'b0;
            rx_overrun_reg  <= 1'b0;
            tx_overflow_reg <= 1'b0;
        end else begin
            if (rx_valid) begin
                // A DATA read finishing on this edge frees the holder for the new byte.
                if (!rx_full_reg || data_clr) begin
                    rx_hold_reg <= rx_byte;
                    rx_full_reg <= 1'b1;
                end
            end else if (data_clr) begin
                rx_full_reg <= 1'b0;
            end

            if (rx_valid && rx_full_reg && !data_clr) begin
                rx_overrun_reg <= 1'b1;
            end else if (stat_clr) begin
                rx_overrun_reg <= 1'b0;
            end

            if (push_req && !push_ok) begin
                tx_overflow_reg <= 1'b1;
            end else if (stat_clr) begin
                tx_overflow_reg <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read path and interrupt
    // ---------------------------------------------------------------
    logic       tx_busy;
    logic [7:0] status;
    logic [7:0] rd_data;

    assign tx_busy = ~fifo_empty | (state_reg != S_IDLE);
    assign status  = {3'b000, tx_overflow_reg, rx_overrun_reg, tx_busy,
                      rx_full_reg, (count_reg != DEPTH_C)};
    assign irq     = rx_full_reg | ~tx_busy;

    always_comb begin
        rd_data = 8'h00;
        case (addr[1:0])
            2'd0:    rd_data = rx_hold_reg;
            2'd1:    rd_data = status;
            default: rd_data = 8'h00;
        endcase
    end

    assign data_out = (~_cs & ~_oe) ? rd_data : 8'bz;

endmodule

// File: tb/tb_device_serial_tx.sv
// Directed bench for device_serial_tx: bus reads/writes, serial frame decoding against an
// expected-byte queue, RX holding register behaviour and asynchronous reset mid-frame.
module tb_device_serial_tx;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = 10 * CPB;

    logic        clk = 1'b0;
    logic        _reset = 1'b0;
    logic        _cs = 1'b1;
    logic        _oe = 1'b1;
    logic        _w = 1'b1;
    logic [19:0] addr = 20'd0;
    logic [7:0]  data_in = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    tri1  [7:0]  data_out;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Frame monitor state and scoreboard
    logic [7:0] exp_q[$];
    int         frame_starts[$];
    int         neg_cnt = 0;
    bit         mon_en = 1'b1;
    bit         mon_active = 1'b0;
    int         mon_idx = 0;
    logic [7:0] mon_shift = 8'h00;
    int         frames_seen = 0;

    always #5 clk = ~clk;

    device_serial_tx #(
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        ._reset  (_reset),
        ._cs     (_cs),
        ._oe     (_oe),
        ._w      (_w),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .tx      (tx),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr    = {18'd0, a};
        data_in = d;
        _cs     = 1'b0;
        _w      = 1'b0;
        tick();
        _cs = 1'b1;
        _w  = 1'b1;
        tick();
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
        addr = {18'd0, a};
        _cs  = 1'b0;
        _oe  = 1'b0;
        @(negedge clk);
        check(tag, data_out, exp);
        tick();
        _cs = 1'b1;
        _oe = 1'b1;
        tick();
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && !mon_active && irq === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 3000) else begin
            errors++;
            $error("FAIL %s: observed timeout with %0d bytes pending expected drained", tag, exp_q.size());
        end
        tick();
    endtask

    initial begin
        int lows;

        // Serial frame monitor: samples mid-bit on falling edges, scoreboards each byte.
        fork
            forever begin
                @(negedge clk);
                neg_cnt++;
                if (!_reset || !mon_en) begin
                    mon_active = 1'b0;
                end else if (!mon_active) begin
                    if (tx == 1'b0) begin
                        mon_active = 1'b1;
                        mon_idx    = 1;
                        frame_starts.push_back(neg_cnt);
                    end
                end else begin
                    if (mon_idx >= 5 && mon_idx <= 33 && ((mon_idx - 5) % 4) == 0) begin
                        mon_shift[(mon_idx - 5) / 4] = tx;
                    end
                    if (mon_idx == 2) begin
                        check("start_bit", {7'd0, tx}, 8'h00);
                    end
                    if (mon_idx == 37) begin
                        check("stop_bit", {7'd0, tx}, 8'h01);
                        frames_seen++;
                        checks++;
                        assert (exp_q.size() != 0) else begin
                            errors++;
                            $error("FAIL unexpected_frame: observed byte %h expected no frame", mon_shift);
                        end
                        if (exp_q.size() != 0) begin
                            check("frame_byte", mon_shift, exp_q.pop_front());
                        end
                    end
                    if (mon_idx == 39) begin
                        mon_active = 1'b0;
                    end else begin
                        mon_idx++;
                    end
                end
            end
        join_none

        // Reset state
        #1;
        check("reset_tx", {7'd0, tx}, 8'h01);
        check("reset_irq", {7'd0, irq}, 8'h01);
        check("reset_bus_released", data_out, 8'hFF);
        repeat (2) tick();
        _reset = 1'b1;
        tick();
        bus_read(2'd1, 8'h01, "status_after_reset");
        check("idle_tx", {7'd0, tx}, 8'h01);
        check("idle_irq", {7'd0, irq}, 8'h01);

        // Single byte, strobe held for three cycles
        exp_q.push_back(8'hA5);
        addr    = 20'd0;
        data_in = 8'hA5;
        _cs     = 1'b0;
        _w      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("tx_high_after_push_edge", {7'd0, tx}, 8'h01);
        @(negedge clk);
        check("tx_low_after_pop_edge", {7'd0, tx}, 8'h00);
        tick();
        _cs = 1'b1;
        _w  = 1'b1;
        tick();
        bus_read(2'd1, 8'h05, "status_busy_midframe");
        wait_drain("drain_a5");
        check("a5_single_frame", 8'(frames_seen), 8'd1);

        // Writes to STATUS and unused offsets are ignored
        bus_write(2'd1, 8'hFF);
        bus_write(2'd2, 8'h77);
        repeat (3) tick();
        bus_read(2'd1, 8'h01, "status_after_ignored_writes");
        bus_read(2'd2, 8'h00, "reg2_reads_zero");
        bus_read(2'd3, 8'h00, "reg3_reads_zero");

        // Six back-to-back writes: five fit (one drains immediately), the sixth overflows
        frame_starts.delete();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
        end
        for (int i = 1; i <= 6; i++) begin
            bus_write(2'd0, 8'(i));
        end
        bus_read(2'd1, 8'h14, "status_full_overflow");
        bus_read(2'd1, 8'h04, "status_overflow_cleared");
        wait_drain("drain_burst");
        check("burst_frame_count", 8'(frame_starts.size()), 8'd5);
        for (int k = 1; k < frame_starts.size(); k++) begin
            check("contiguous_frame_spacing", 8'(frame_starts[k] - frame_starts[k-1]), 8'(FRAME_LEN));
        end

        // RX holding register
        pulse_rx(8'h3C);
        check("irq_rx_full", {7'd0, irq}, 8'h01);
        bus_read(2'd1, 8'h03, "status_rx_full");
        bus_read(2'd0, 8'h3C, "rx_data_3c");
        bus_read(2'd1, 8'h01, "status_rx_cleared");

        // Overrun keeps the first byte
        pulse_rx(8'h11);
        pulse_rx(8'h22);
        bus_read(2'd0, 8'h11, "rx_data_kept_11");
        bus_read(2'd1, 8'h09, "status_overrun");
        bus_read(2'd1, 8'h01, "status_overrun_cleared");

        // DATA-read end coincident with a new byte
        pulse_rx(8'h44);
        addr = 20'd0;
        _cs  = 1'b0;
        _oe  = 1'b0;
        @(negedge clk);
        check("rx_data_44", data_out, 8'h44);
        tick();
        _cs      = 1'b1;
        _oe      = 1'b1;
        rx_byte  = 8'h33;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        bus_read(2'd1, 8'h03, "status_coincident_no_overrun");
        bus_read(2'd0, 8'h33, "rx_data_33");

        // Asynchronous reset in the middle of a data bit with bytes still queued
        mon_en = 1'b0;
        bus_write(2'd0, 8'hC1);
        bus_write(2'd0, 8'hC2);
        bus_write(2'd0, 8'hC3);
        repeat (6) tick();
        #2;
        _reset = 1'b0;
        #1;
        check("reset_midframe_tx", {7'd0, tx}, 8'h01);
        check("reset_midframe_irq", {7'd0, irq}, 8'h01);
        repeat (2) tick();
        _reset = 1'b1;
        tick();
        mon_en = 1'b1;
        bus_read(2'd1, 8'h01, "status_after_midframe_reset");
        lows = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_frames_after_reset", 8'(lows), 8'd0);
        check("no_pending_expected", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/device_serial_tx.md
Name: device_serial_tx

Overview:
- Memory-mapped console device: the responder on the main 8-bit bus in the device region (bus_addr[23:20] = 4'b0111).
- The CPU sequencer is the bus initiator; this block is the target end of the same _cs/_oe/_w handshake that main_ram uses.
- Accepted write bytes are queued in a small TX FIFO and shifted out as 8N1 serial.
- A single-byte RX holding register, loaded by the host/bench side, is readable by the CPU.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, minimum 2
CLKS_PER_BIT, 4, clk cycles per serial bit; minimum 2

Ports:
clk  input  1  system clock; all state updates on rising edge
_reset  input  1  asynchronous, active-low reset
_cs  input  1  active-low device select (addr_device)
_oe  input  1  active-low output enable (read)
_w  input  1  active-low write strobe
addr  input  20  bus address; only addr[1:0] decoded
data_in  input  8  bus write data
data_out  output  8  bus read data; 8'bz when not (_cs=0 & _oe=0)
tx  output  1  serial out, idle high
rx_valid  input  1  one-cycle pulse: rx_byte is valid
rx_byte  input  8  byte from host side
irq  output  1  high when rx_full=1 or (TX FIFO empty and serializer idle)

Behaviour:
- Register map (addr[1:0]):
  - 0 DATA: write pushes the TX FIFO; read returns rx_hold.
  - 1 STATUS: read only; writes ignored.
  - 2, 3: read 8'h00; writes ignored.
- STATUS bits:
  - [0] tx_not_full
  - [1] rx_full
  - [2] tx_busy (FIFO non-empty or serializer active)
  - [3] rx_overrun (sticky)
  - [4] tx_overflow (sticky)
  - [7:5] = 0
- Write strobe:
  - wr_act = ~_cs & ~_w, registered once per clk.
  - A push happens on the first clk edge where wr_act=1 and the previous sample was 0.
  - Exactly one push per strobe, however long _w is held.
  - data_in is sampled at that edge.
- Read strobe:
  - rd_act = ~_cs & ~_oe; data_out is combinational from the current register state.
  - Side effects fire on the clk edge where rd_act goes 1->0 (previous sample 1, current 0). addr is taken from the last cycle rd_act was 1.
  - End of a DATA read clears rx_full.
  - End of a STATUS read clears rx_overrun and tx_overflow.
  - If _w and _oe are both low, the write takes priority and no read side effect occurs.
- TX FIFO:
  - Circular buffer with wrapping read/write pointers and a count of 0..FIFO_DEPTH.
  - A push is accepted if count<FIFO_DEPTH, or if count=FIFO_DEPTH and a pop occurs on the same edge.
  - Otherwise the byte is dropped, tx_overflow is set, and FIFO contents are unchanged.
- Serializer states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; bit index 0..7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START directly (no idle gap); else go to IDLE.
- TX latency and frame length:
  - Push at edge N into an empty FIFO with the serializer idle -> pop at edge N+1, tx low from edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- RX holding register:
  - rx_valid with rx_full=0: load rx_hold, set rx_full.
  - rx_valid with rx_full=1 and no DATA-read clear on that edge: discard the byte, keep rx_hold, set rx_overrun.
  - rx_valid and a DATA-read clear on the same edge: load the new byte, rx_full stays 1, no overrun.
- Reset, asynchronous, mid-operation included:
  - tx=1, serializer IDLE, FIFO empty with pointers 0.
  - rx_hold=0, rx_full=0, both sticky bits 0, strobe history 0.
  - irq=1; data_out follows the rule above.
  - A frame in progress is abandoned, with no partial stop bit.

Test Plan:
- Reset then STATUS read -> 8'h01; tx=1; irq=1; data_out=8'bz with _oe=1.
- Write 8'hA5 to addr 0 with _w held low for 3 cycles -> exactly one frame: tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 clks, 40 clks total; STATUS[2]=1 during the frame.
- Write 6 bytes 8'h01..8'h06 back-to-back (one strobe each, 2 clks apart) -> 01..05 transmitted contiguously with no idle between stop and start; 06 dropped; STATUS read returns tx_overflow=1, and a second STATUS read returns bit4=0.
- rx_valid with 8'h3C -> STATUS[1]=1, irq=1. DATA read returns 8'h3C; rx_full=0 after the _oe rise.
- Two rx_valid pulses (8'h11 then 8'h22) with no read -> DATA reads 8'h11, STATUS[3]=1. DATA-read end coincident with rx_valid 8'h33 -> rx_hold=8'h33, rx_full=1, no new overrun.
- Assert _reset low mid-DATA-bit of a frame with 2 bytes queued -> tx=1 immediately, STATUS=8'h01 after release, no further frames.
